// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access sequencer: Zicsr op codes, FSM states, privilege levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package csr_pkg;

    // Low two bits of funct3 for the Zicsr instructions
    typedef enum logic [1:0] {
        OP_INV = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        MERGE = 3'd3,
        WRITE = 3'd4,
        RESP  = 3'd5
    } state_e;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // csr_addr[11:10] value that marks a CSR as read-only
    localparam logic [1:0] RO_FIELD = 2'b11;

    // Illegal when the op is reserved, the CSR needs more privilege than we have,
    // or a write is attempted to a read-only CSR.
    function automatic logic csr_illegal(input logic [1:0] op,
                                         input logic [1:0] addr_priv,
                                         input logic [1:0] addr_ro,
                                         input logic [1:0] priv,
                                         input logic       do_write);
        return (op == OP_INV) || (addr_priv > priv) || ((addr_ro == RO_FIELD) && do_write);
    endfunction

endpackage

// File: rtl/csr_wdata_merge.sv
// Combines the old CSR value with the source operand according to the Zicsr op.
// Latency: purely combinational.
// Backpressure: none.
module csr_wdata_merge
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] merged
);

    // RW replaces, RS sets bits, RC clears bits; the reserved op leaves the value untouched
    always_comb begin
        merged = old;
        case (op)
            OP_RW:   merged = src;
            OP_RS:   merged = old | src;
            OP_RC:   merged = old & ~src;
            default: merged = old;
        endcase
    end

endmodule

// File: rtl/csr_access_sequencer.sv
// Runs one Zicsr instruction at a time: privilege/RO check, CSR read, merge, write-back, response.
// Latency: read+write path rd_en at T1, wr_en at T3, resp_valid at T4 after accept at T0.
// Backpressure: one request in flight; response held until resp_ready_in; flush aborts anywhere.
module csr_access_sequencer
    import csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12,
    parameter int PRIV_W = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [2:0]        csr_funct3_in,
    input  logic [CSR_AW-1:0] csr_addr_in,
    input  logic [XLEN-1:0]   rs1_data_in,
    input  logic [4:0]        zimm_in,
    input  logic              rs1_is_x0_in,
    input  logic              rd_is_x0_in,
    input  logic [PRIV_W-1:0] priv_in,
    input  logic              flush_in,
    output logic              csr_rd_en_out,
    output logic [CSR_AW-1:0] csr_rd_addr_out,
    input  logic [XLEN-1:0]   csr_rd_data_in,
    output logic              csr_wr_en_out,
    output logic [CSR_AW-1:0] csr_wr_addr_out,
    output logic [XLEN-1:0]   csr_wr_data_out,
    output logic              resp_valid_out,
    input  logic              resp_ready_in,
    output logic [XLEN-1:0]   resp_rdata_out,
    output logic              resp_illegal_out,
    output logic              busy_out
);

    state_e            state;
    state_e            state_nxt;

    logic [1:0]        op_q;
    logic [CSR_AW-1:0] addr_q;
    logic [XLEN-1:0]   src_q;
    logic [PRIV_W-1:0] priv_q;
    logic              src_zero_q;
    logic              rd_x0_q;
    logic              illegal_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   new_q;

    logic              accept;
    logic              do_write;
    logic              do_read;
    logic              illegal;
    logic [XLEN-1:0]   merge_old;
    logic [XLEN-1:0]   merge_out;

    assign accept   = req_valid_in && req_ready_out;
    assign do_write = (op_q == OP_RW) || !src_zero_q;
    assign do_read  = !((op_q == OP_RW) && rd_x0_q);
    assign illegal  = csr_illegal(op_q, addr_q[9:8], addr_q[11:10], priv_q, do_write);

    // The merge sees the read data directly in READ so the write can follow on the
    // very next cycle; on the no-read path MERGE feeds it the cleared old value.
    assign merge_old = (state == READ) ? csr_rd_data_in : old_q;

    csr_wdata_merge #(
        .XLEN (XLEN)
    ) u_merge (
        .op     (op_q),
        .old    (merge_old),
        .src    (src_q),
        .merged (merge_out)
    );

    // State register; async reset drops straight to IDLE so every strobe decoded from it falls at once
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a flush outside IDLE abandons the request and any pending response
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = CHECK;
            end
            CHECK: begin
                if (illegal)      state_nxt = RESP;
                else if (do_read) state_nxt = READ;
                else              state_nxt = MERGE;
            end
            READ:  state_nxt = do_write ? WRITE : RESP;
            MERGE: state_nxt = do_write ? WRITE : RESP;
            WRITE: state_nxt = RESP;
            RESP: begin
                if (resp_ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_in && (state != IDLE)) state_nxt = IDLE;
    end

    // Request fields are captured at accept; old/new values are filled in as the sequence advances
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            op_q       <= OP_INV;
            addr_q     <= '0;
            src_q      <= '0;
            priv_q     <= '0;
            src_zero_q <= 1'b0;
            rd_x0_q    <= 1'b0;
            illegal_q  <= 1'b0;
            old_q      <= '0;
            new_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= csr_funct3_in[1:0];
                        addr_q     <= csr_addr_in;
                        src_q      <= csr_funct3_in[2] ? {{(XLEN-5){1'b0}}, zimm_in} : rs1_data_in;
                        priv_q     <= priv_in;
                        src_zero_q <= csr_funct3_in[2] ? (zimm_in == 5'd0) : rs1_is_x0_in;
                        rd_x0_q    <= rd_is_x0_in;
                        illegal_q  <= 1'b0;
                        old_q      <= '0;
                    end
                end
                CHECK: begin
                    illegal_q <= illegal;
                end
                READ: begin
                    old_q <= csr_rd_data_in;
                    new_q <= merge_out;
                end
                MERGE: begin
                    new_q <= merge_out;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_out    = (state == IDLE) && !flush_in;
    assign csr_rd_en_out    = (state == CHECK) && !illegal && do_read;
    assign csr_rd_addr_out  = addr_q;
    assign csr_wr_en_out    = (state == WRITE) && !flush_in;
    assign csr_wr_addr_out  = addr_q;
    assign csr_wr_data_out  = new_q;
    assign resp_valid_out   = (state == RESP);
    assign resp_rdata_out   = old_q;
    assign resp_illegal_out = (state == RESP) && illegal_q;
    assign busy_out         = (state != IDLE);

endmodule
